// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, arbiter state
// encoding and the write-request bundle.
package wb_port_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: MDU result queue with per-entry valid
// bits so pipeline writes can kill stale results in place.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    input  logic          i_kill,
    input  logic [AW-1:0] i_kill_addr,
    output logic          o_full,
    output logic          o_head_valid,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic          o_empty_nxt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;

    logic [DEPTH-1:0] w_vld;
    logic [PW-1:0]    w_head;
    logic [CW-1:0]    w_skip;
    logic [CW-1:0]    w_npop;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_found;
    logic             w_push_ok;

    // Entries whose rd matches this cycle's pipeline write are dead
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_vld[j] = r_vld[j] &&
                       !(i_kill && (r_addr[j] == i_kill_addr));
        end
    end

    // Head is the oldest live entry; dead ones ahead of it drop for free
    always_comb begin
        w_found = 1'b0;
        w_skip  = '0;
        w_head  = r_rd;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && (CW'(i) < r_cnt)) begin
                if (w_vld[r_rd + PW'(i)]) begin
                    w_found = 1'b1;
                    w_head  = r_rd + PW'(i);
                end else begin
                    w_skip = w_skip + CW'(1);
                end
            end
        end
    end

    assign o_full       = (r_cnt == CW'(DEPTH));
    assign w_push_ok    = i_push && !o_full;
    assign o_head_valid = w_found;
    assign o_head_addr  = r_addr[w_head];
    assign o_head_data  = r_data[w_head];
    assign w_npop       = w_skip + CW'(i_pop && w_found);
    assign w_cnt_nxt    = r_cnt - w_npop + CW'(w_push_ok);
    assign o_empty_nxt  = (w_cnt_nxt == '0);

    // Pointers, occupancy and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_vld <= '0;
        end else begin
            r_vld <= w_vld;
            if (w_push_ok) begin
                r_vld[r_wr] <= 1'b1;
            end
            r_rd  <= r_rd + PW'(w_npop);
            r_wr  <= r_wr + PW'(w_push_ok);
            r_cnt <= w_cnt_nxt;
        end
    end

    // Payload storage needs no reset; occupancy guards it
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_addr[r_wr] <= i_push_addr;
            r_data[r_wr] <= i_push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regs write port between the
// in-order pipeline and queued mul/div results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_waddr_i,
    input  logic [DATA_W-1:0] pipe_wdata_i,
    input  logic              mdu_valid_i,
    output logic              mdu_ready_o,
    input  logic [ADDR_W-1:0] mdu_waddr_i,
    input  logic [DATA_W-1:0] mdu_wdata_i,
    output logic              stall_o,
    output logic              wb_reg_we_o,
    output logic [ADDR_W-1:0] wb_reg_waddr_o,
    output logic [DATA_W-1:0] wb_op_c_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_stall;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_full;
    logic              w_head_vld;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_empty_nxt;
    logic              w_pipe_win;
    logic              w_push;
    logic              w_pop;
    logic              w_lost;

    assign mdu_ready_o = !w_full;
    assign w_pipe_win  = pipe_we_i && (pipe_waddr_i != '0) && !r_stall;
    assign w_push      = mdu_valid_i && !w_full && (mdu_waddr_i != '0);
    assign w_pop       = !w_pipe_win && w_head_vld;
    assign w_lost      = w_pipe_win && w_head_vld;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_addr  (mdu_waddr_i),
        .i_push_data  (mdu_wdata_i),
        .i_pop        (w_pop),
        .i_kill       (w_pipe_win),
        .i_kill_addr  (pipe_waddr_i),
        .o_full       (w_full),
        .o_head_valid (w_head_vld),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_empty_nxt  (w_empty_nxt)
    );

    // Starve counter and state transitions
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_pop) begin
            w_cnt_nxt = '0;
        end else if (w_lost && (r_cnt != CW'(STARVE_LIMIT))) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_push) w_state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (w_empty_nxt) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_nxt == CW'(STARVE_LIMIT)) begin
                    w_state_nxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (w_empty_nxt) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt == ST_IDLE) begin
            w_cnt_nxt = '0;
        end
    end

    // FSM, counter and registered stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stall <= (w_state_nxt == ST_FORCE);
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_pipe_win) begin
            r_we    <= 1'b1;
            r_waddr <= pipe_waddr_i;
            r_wdata <= pipe_wdata_i;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_waddr <= w_head_addr;
            r_wdata <= w_head_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign stall_o        = r_stall;
    assign wb_reg_we_o    = r_we;
    assign wb_reg_waddr_o = r_waddr;
    assign wb_op_c_o      = r_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ready;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          stall;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    wb_req_t       mq[$];
    int            m_lost = 0;
    bit            m_stall = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;

    wb_port_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_we_i      (p_we),
        .pipe_waddr_i   (p_addr),
        .pipe_wdata_i   (p_data),
        .mdu_valid_i    (m_valid),
        .mdu_ready_o    (m_ready),
        .mdu_waddr_i    (m_addr),
        .mdu_wdata_i    (m_data),
        .stall_o        (stall),
        .wb_reg_we_o    (wb_we),
        .wb_reg_waddr_o (wb_addr),
        .wb_op_c_o      (wb_data)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_lost  = 0;
        m_stall = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    // One slot of the rules: kill, drop dead heads, grant, push
    task automatic model_step();
        bit      rdy;
        bit      win;
        wb_req_t h;
        rdy = (mq.size() < DEPTH);
        win = p_we && (p_addr != 0) && !m_stall;
        if (win) begin
            foreach (mq[i]) begin
                if (mq[i].waddr == p_addr) mq[i].we = 1'b0;
            end
        end
        while (mq.size() > 0 && !mq[0].we) void'(mq.pop_front());
        if (win) begin
            e_we   = 1'b1;
            e_addr = p_addr;
            e_data = p_data;
            if (mq.size() > 0 && m_lost < LIMIT) m_lost++;
        end else if (mq.size() > 0) begin
            h      = mq.pop_front();
            e_we   = 1'b1;
            e_addr = h.waddr;
            e_data = h.wdata;
            m_lost = 0;
        end else begin
            e_we = 1'b0;
        end
        if (m_valid && rdy && m_addr != 0) begin
            mq.push_back('{we: 1'b1, waddr: m_addr, wdata: m_data});
        end
        if (mq.size() == 0) begin
            m_stall = 1'b0;
            m_lost  = 0;
        end else if (m_lost >= LIMIT) begin
            m_stall = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        p_we    = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wb_we, wb_addr, wb_data, stall} !== '0 || m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init we=%0b a=%0d d=%h st=%0b rdy=%0b exp all 0, rdy 1",
                     wb_we, wb_addr, wb_data, stall, m_ready);
        end
        rst_n = 1'b1;
        p_we = 1'b1; p_addr = 5'd3; p_data = 32'h1;
        m_valid = 1'b1; m_addr = 5'd10; m_data = 32'hA;
        tick();
        m_addr = 5'd11; m_data = 32'hB;
        tick();
        n_checks++;
        if (m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_prefull rdy=%0b exp 0", m_ready);
        end
        p_we = 1'b0; m_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({wb_we, wb_addr, wb_data, stall} !== '0 || m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid we=%0b a=%0d d=%h st=%0b rdy=%0b exp all 0, rdy 1",
                     wb_we, wb_addr, wb_data, stall, m_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        n_checks++;
        if (wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard we=%0b exp 0", wb_we);
        end
    endtask

    task automatic test_mdu_only();
        m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hDEADBEEF;
        tick();
        m_valid = 1'b0;
        n_checks++;
        if (wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mdu_same_cycle we=%0b exp 0", wb_we);
        end
        tick();
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL mdu_write we=%0b a=%0d d=%h exp 1/5/deadbeef",
                     wb_we, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if (wb_we !== 1'b0 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL mdu_hold we=%0b a=%0d d=%h exp 0/5/deadbeef",
                     wb_we, wb_addr, wb_data);
        end
    endtask

    task automatic test_contention();
        int first_stall = -1;
        int wr7 = -1;
        int n_stall = 0;
        m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h77;
        tick();
        m_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            p_we = 1'b1; p_addr = 5'd3; p_data = 32'(k);
            tick();
            n_checks++;
            if (wb_we !== e_we || wb_addr !== e_addr ||
                wb_data !== e_data || stall !== m_stall) begin
                n_fail++;
                $display("FAIL cont_cyc%0d we=%0b a=%0d d=%h st=%0b exp %0b/%0d/%h/%0b",
                         k, wb_we, wb_addr, wb_data, stall,
                         e_we, e_addr, e_data, m_stall);
            end
            if (stall === 1'b1) begin
                n_stall++;
                if (first_stall < 0) first_stall = k;
            end
            if (wb_we === 1'b1 && wb_addr === 5'd7 && wr7 < 0) wr7 = k;
        end
        p_we = 1'b0;
        n_checks++;
        if (first_stall != 3 || wr7 != 4 || n_stall != 1) begin
            n_fail++;
            $display("FAIL cont_timing stall_at=%0d wr7_at=%0d stall_cycles=%0d exp 3/4/1",
                     first_stall, wr7, n_stall);
        end
    endtask

    task automatic test_waw();
        int bad = 0;
        m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h11;
        tick();
        m_valid = 1'b0;
        p_we = 1'b1; p_addr = 5'd9; p_data = 32'h22;
        tick();
        p_we = 1'b0;
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h22) begin
            n_fail++;
            $display("FAIL waw_pipe we=%0b a=%0d d=%h exp 1/9/22",
                     wb_we, wb_addr, wb_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_we === 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL waw_kill extra_writes=%0d exp 0", bad);
        end
    endtask

    task automatic test_full();
        p_we = 1'b1; p_addr = 5'd2; p_data = 32'hA0;
        m_valid = 1'b1; m_addr = 5'd12; m_data = 32'hC1;
        tick();
        m_addr = 5'd13; m_data = 32'hC2;
        tick();
        n_checks++;
        if (m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready rdy=%0b exp 0", m_ready);
        end
        m_addr = 5'd14; m_data = 32'hC3;
        tick();
        n_checks++;
        if (m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_held rdy=%0b exp 0", m_ready);
        end
        p_we = 1'b0;
        tick();
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd12 || m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop1 we=%0b a=%0d rdy=%0b exp 1/12/1",
                     wb_we, wb_addr, m_ready);
        end
        tick();
        m_valid = 1'b0;
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd13 || wb_data !== 32'hC2) begin
            n_fail++;
            $display("FAIL full_pop2 we=%0b a=%0d d=%h exp 1/13/c2",
                     wb_we, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd14 || wb_data !== 32'hC3) begin
            n_fail++;
            $display("FAIL full_accept we=%0b a=%0d d=%h exp 1/14/c3",
                     wb_we, wb_addr, wb_data);
        end
    endtask

    task automatic test_x0();
        m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h44;
        tick();
        p_we = 1'b1; p_addr = 5'd0; p_data = 32'h99;
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h55;
        n_checks++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready rdy=%0b exp 1", m_ready);
        end
        tick();
        p_we = 1'b0; m_valid = 1'b0;
        n_checks++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 32'h44) begin
            n_fail++;
            $display("FAIL x0_slot we=%0b a=%0d d=%h exp 1/4/44",
                     wb_we, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if (wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_drop we=%0b a=%0d exp we 0", wb_we, wb_addr);
        end
    endtask

    task automatic test_random();
        bit acc = 1'b0;
        bit rdy_exp;
        for (int c = 0; c < 400; c++) begin
            p_we   = ($urandom_range(0, 99) < 55);
            p_addr = AW'($urandom_range(0, 11));
            p_data = $urandom;
            if (!m_valid || acc) begin
                m_valid = ($urandom_range(0, 99) < 45);
                m_addr  = AW'($urandom_range(0, 11));
                m_data  = $urandom;
            end
            rdy_exp = (mq.size() < DEPTH);
            acc     = m_valid && rdy_exp;
            n_checks++;
            if (m_ready !== rdy_exp) begin
                n_fail++;
                $display("FAIL rnd_ready cyc%0d rdy=%0b exp %0b", c, m_ready, rdy_exp);
            end
            tick();
            n_checks++;
            if (wb_we !== e_we || wb_addr !== e_addr ||
                wb_data !== e_data || stall !== m_stall) begin
                n_fail++;
                $display("FAIL rnd_out cyc%0d we=%0b a=%0d d=%h st=%0b exp %0b/%0d/%h/%0b",
                         c, wb_we, wb_addr, wb_data, stall,
                         e_we, e_addr, e_data, m_stall);
            end
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        idle(2);
        test_mdu_only();
        idle(2);
        test_contention();
        idle(2);
        test_waw();
        idle(2);
        test_full();
        idle(2);
        test_x0();
        idle(2);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
